fir_seq_ctrl: RTL

Sequencer for the band FIR filters (LP/B1/B2/HP). Each filter takes paired left/right samples and a `sequencing` window, and accumulates only while `sequencing` is high.
- Manages the circular sample buffer of DEPTH entries: write pointer, warm-up fill count and read address.
- On each new sample, opens one `sequencing` window of exactly NUM_TAPS+1 cycles shared by all band filters.
- Flags when filter outputs are valid.

---
 rtl/fir_seq_ctrl_if.sv | 24 ++
 rtl/fir_seq_ctrl.sv | 130 +++++++++++++
 2 files changed

// File: rtl/fir_seq_ctrl_if.sv
// rtl/fir_seq_ctrl_if.sv - sample-buffer and band-FIR sequencing bus for fir_seq_ctrl
interface fir_seq_ctrl_if #(
   parameter int AW = 10
);
   logic          smpl_vld;
   logic          clr_err;
   logic          wr_en;
   logic [AW-1:0] wr_addr;
   logic [AW-1:0] rd_addr;
   logic          sequencing;
   logic          filt_vld;
   logic          busy;
   logic          ovr_err;

   modport master (
      input  smpl_vld, clr_err,
      output wr_en, wr_addr, rd_addr, sequencing, filt_vld, busy, ovr_err
   );

   modport slave (
      output smpl_vld, clr_err,
      input  wr_en, wr_addr, rd_addr, sequencing, filt_vld, busy, ovr_err
   );
endinterface

// File: rtl/fir_seq_ctrl.sv
// rtl/fir_seq_ctrl.sv - circular-buffer sequencer for the band FIRs; SEQ_PEND_EN adds a one-deep pending window slot
module fir_seq_ctrl #(
   parameter int NUM_TAPS = 1021,
   parameter int AW       = 10
) (
   input  logic           clk,
   input  logic           rst,
   fir_seq_ctrl_if.master bus
);
   localparam int            DEPTH     = 2 ** AW;
   localparam int            KW        = $clog2(NUM_TAPS + 1);
   localparam logic [AW-1:0] TAPS_A    = AW'(NUM_TAPS % DEPTH);
   localparam logic [KW-1:0] K_LAST    = KW'(NUM_TAPS);
   localparam logic [KW-1:0] FILL_LAST = KW'(NUM_TAPS - 1);

   typedef enum logic [1:0] {FILL, IDLE, SEQ, DONE} state_t;

   state_t        state;
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_addr;
   logic [KW-1:0] k;
   logic [KW-1:0] fill_cnt;
   logic          sequencing;
   logic          filt_vld;
   logic          busy;
   logic          ovr_err;
`ifdef SEQ_PEND_EN
   logic          pend_vld;
   logic [AW-1:0] base_pend;
`endif

   assign bus.wr_en      = bus.smpl_vld;
   assign bus.wr_addr    = wr_ptr;
   assign bus.rd_addr    = rd_addr;
   assign bus.sequencing = sequencing;
   assign bus.filt_vld   = filt_vld;
   assign bus.busy       = busy;
   assign bus.ovr_err    = ovr_err;

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= FILL;
         wr_ptr     <= '0;
         rd_addr    <= '0;
         k          <= '0;
         fill_cnt   <= '0;
         sequencing <= 1'b0;
         filt_vld   <= 1'b0;
         busy       <= 1'b0;
         ovr_err    <= 1'b0;
`ifdef SEQ_PEND_EN
         pend_vld   <= 1'b0;
         base_pend  <= '0;
`endif
      end else begin
         filt_vld <= 1'b0;
         if (bus.smpl_vld) wr_ptr <= wr_ptr + 1'b1;
         // Clear first so a coincident overrun below takes priority
         if (bus.clr_err) ovr_err <= 1'b0;

         case (state)
            FILL: begin
               if (bus.smpl_vld) begin
                  fill_cnt <= fill_cnt + 1'b1;
                  if (fill_cnt == FILL_LAST) begin
                     state      <= SEQ;
                     sequencing <= 1'b1;
                     busy       <= 1'b1;
                     k          <= '0;
                     rd_addr    <= wr_ptr - TAPS_A;
                  end
               end
            end

            IDLE: begin
               if (bus.smpl_vld) begin
                  state      <= SEQ;
                  sequencing <= 1'b1;
                  busy       <= 1'b1;
                  k          <= '0;
                  rd_addr    <= wr_ptr - TAPS_A;
               end
            end

            SEQ: begin
               if (k == K_LAST) begin
                  state      <= DONE;
                  sequencing <= 1'b0;
                  busy       <= 1'b0;
                  filt_vld   <= 1'b1;
               end else begin
                  k       <= k + 1'b1;
                  rd_addr <= rd_addr + 1'b1;
               end
`ifdef SEQ_PEND_EN
               if (bus.smpl_vld) begin
                  pend_vld  <= 1'b1;
                  base_pend <= wr_ptr;
                  if (pend_vld) ovr_err <= 1'b1;
               end
`else
               if (bus.smpl_vld) ovr_err <= 1'b1;
`endif
            end

            DONE: begin
`ifdef SEQ_PEND_EN
               // A sample landing in DONE is scheduled straight away, newest base wins
               if (bus.smpl_vld || pend_vld) begin
                  state      <= SEQ;
                  sequencing <= 1'b1;
                  busy       <= 1'b1;
                  k          <= '0;
                  rd_addr    <= (bus.smpl_vld ? wr_ptr : base_pend) - TAPS_A;
                  pend_vld   <= 1'b0;
                  if (bus.smpl_vld && pend_vld) ovr_err <= 1'b1;
               end else begin
                  state <= IDLE;
               end
`else
               if (bus.smpl_vld) ovr_err <= 1'b1;
               state <= IDLE;
`endif
            end

            default: state <= FILL;
         endcase
      end
   end
endmodule
